// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the 2-input gate checker.
package gate_checker_pkg;

    // Checker sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_CHECK  = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // Expected-output tables, bit i is the gate output for {a,b} = i
    localparam logic [3:0] NOR_TT  = 4'b0001;
    localparam logic [3:0] NAND_TT = 4'b0111;
    localparam logic [3:0] AND_TT  = 4'b1000;
    localparam logic [3:0] OR_TT   = 4'b1110;

    // Number of input vectors applied in one run
    localparam int NUM_VECTORS = 4;

endpackage

// File: rtl/gate_checker_sync2.sv
// Two-flop synchronizer bringing the gate output into the clk domain.
module sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Shift the asynchronous input through two flops; clear both on reset
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/gate_checker.sv
// Drives all four input vectors onto a 2-input gate, samples its output
// after a settle time and compares against a truth table.
//
// Handshake: start is a level sampled only in IDLE (and not in the cycle
// done is high); a run then cannot be interrupted except by reset. done is
// a one-cycle pulse; pass, err_count and fail_vec hold until the next
// accepted start.
module gate_checker
    import gate_checker_pkg::*;
#(
    parameter int         SETTLE_CYCLES = 10,
    parameter logic [3:0] TRUTH         = NOR_TT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec,
    output logic [1:0] dbg_state
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_IDX    = 2'(NUM_VECTORS - 1);
    localparam logic [2:0] ERR_MAX     = 3'(NUM_VECTORS);

    state_t     r_state;
    logic [1:0] r_idx;
    logic [7:0] r_settle;
    logic       r_a;
    logic       r_b;
    logic       r_busy;
    logic       r_done;
    logic       r_pass;
    logic [2:0] r_err;
    logic [3:0] r_fail;
    logic       w_y_sync;
    logic [1:0] w_idx_next;

    sync2 u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (y_in),
        .o_q     (w_y_sync)
    );

    assign w_idx_next = r_idx + 2'd1;

    // Run sequencer: all state and registered outputs in one block
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_idx    <= 2'd0;
            r_settle <= 8'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= 3'd0;
            r_fail   <= 4'd0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The done cycle is spent in IDLE, so block a start there
                    if (start && !r_done) begin
                        r_state  <= ST_APPLY;
                        r_idx    <= 2'd0;
                        r_settle <= 8'd0;
                        r_a      <= 1'b0;
                        r_b      <= 1'b0;
                        r_busy   <= 1'b1;
                        r_pass   <= 1'b0;
                        r_err    <= 3'd0;
                        r_fail   <= 4'd0;
                    end
                end
                ST_APPLY: begin
                    if (r_settle == SETTLE_LAST) begin
                        r_settle <= 8'd0;
                        r_state  <= ST_CHECK;
                    end else begin
                        r_settle <= r_settle + 8'd1;
                    end
                end
                ST_CHECK: begin
                    if (w_y_sync != TRUTH[r_idx]) begin
                        r_fail[r_idx] <= 1'b1;
                        if (r_err < ERR_MAX) begin
                            r_err <= r_err + 3'd1;
                        end
                    end
                    if (r_idx == LAST_IDX) begin
                        r_state <= ST_FINISH;
                        r_a     <= 1'b0;
                        r_b     <= 1'b0;
                    end else begin
                        r_state <= ST_APPLY;
                        r_idx   <= w_idx_next;
                        r_a     <= w_idx_next[1];
                        r_b     <= w_idx_next[0];
                    end
                end
                ST_FINISH: begin
                    // r_err already includes the last compare here
                    r_done  <= 1'b1;
                    r_pass  <= (r_err == 3'd0);
                    r_busy  <= 1'b0;
                    r_idx   <= 2'd0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_a     <= 1'b0;
                    r_b     <= 1'b0;
                end
            endcase
        end
    end

    assign a_out     = r_a;
    assign b_out     = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_vec  = r_fail;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_gate_checker.sv
// Directed bench for gate_checker: default NOR instance plus a NAND/3-cycle
// instance, each fed by a selectable behavioural gate.
module tb_gate_checker;
    import gate_checker_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start1, start2;
    logic       a1, b1, y1, busy1, done1, pass1;
    logic       a2, b2, y2, busy2, done2, pass2;
    logic [2:0] err1, err2;
    logic [3:0] fail1, fail2;
    logic [1:0] st1, st2;
    int         mode1;   // 0 NOR, 1 stuck-at-1, 2 OR
    int         mode2;   // 0 NAND, 1 NOR

    int n_vec = 0;
    int n_bad = 0;

    assign y1 = (mode1 == 0) ? ~(a1 | b1) : (mode1 == 1) ? 1'b1 : (a1 | b1);
    assign y2 = (mode2 == 0) ? ~(a2 & b2) : ~(a2 | b2);

    gate_checker u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1),
        .y_in(y1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .fail_vec(fail1), .dbg_state(st1)
    );

    gate_checker #(.SETTLE_CYCLES(3), .TRUTH(NAND_TT)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2),
        .y_in(y2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .fail_vec(fail2), .dbg_state(st2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One run on dut1; optional extra start pulses during the run
    task automatic run1(input bit repulse, output int done_cyc, output int done_cnt);
        done_cyc = -1;
        done_cnt = 0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            start1 = (repulse && (n == 5 || n == 20)) ? 1'b1 : 1'b0;
            if (done1) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = n;
            end
            case (n)
                1:  check("busy_in_run", 32'(busy1), 32'd1);
                3:  check("ab_vec0", 32'({a1, b1}), 32'd0);
                14: check("ab_vec1", 32'({a1, b1}), 32'd1);
                25: check("ab_vec2", 32'({a1, b1}), 32'd2);
                36: check("ab_vec3", 32'({a1, b1}), 32'd3);
                44: check("ab_finish", 32'({a1, b1}), 32'd0);
                45: check("busy_at_done", 32'(busy1), 32'd0);
                default: ;
            endcase
        end
        start1 = 1'b0;
    endtask

    task automatic run2(output int done_cyc);
        done_cyc = -1;
        start2 = 1'b1;
        @(posedge clk); #1;
        start2 = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(posedge clk); #1;
            if (done2 && done_cyc < 0) done_cyc = n;
        end
    endtask

    initial begin
        int dc, cnt;
        bit seen;
        rst_n = 1'b0; start1 = 1'b0; start2 = 1'b0; mode1 = 0; mode2 = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ab", 32'({a1, b1}), 32'd0);
        check("rst_flags", 32'({busy1, done1, pass1}), 32'd0);
        check("rst_err_fail", 32'({err1, fail1}), 32'd0);
        check("rst_state", 32'(st1), 32'd0);
        check("rst_dut2", 32'({a2, b2, busy2, done2, pass2, err2, fail2}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean NOR gate, default settle
        run1(1'b0, dc, cnt);
        check("nor_done_cycle", 32'(dc), 32'd45);
        check("nor_done_once", 32'(cnt), 32'd1);
        check("nor_pass", 32'(pass1), 32'd1);
        check("nor_err", 32'(err1), 32'd0);
        check("nor_fail", 32'(fail1), 32'd0);

        // Start re-pulsed mid-run is ignored
        run1(1'b1, dc, cnt);
        check("repulse_done_cycle", 32'(dc), 32'd45);
        check("repulse_done_once", 32'(cnt), 32'd1);
        check("repulse_pass", 32'(pass1), 32'd1);
        check("repulse_err_fail", 32'({err1, fail1}), 32'd0);

        // Start held in the done cycle is ignored
        seen = 1'b0;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        for (int n = 1; n <= 60 && !seen; n++) begin
            @(posedge clk); #1;
            if (done1) seen = 1'b1;
        end
        check("done_seen", 32'(seen), 32'd1);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("start_at_done_ignored", 32'(busy1), 32'd0);
        @(posedge clk); #1;

        // Reset during idx=2 APPLY, with an OR gate so errors have accrued
        mode1 = 2;
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (25) @(posedge clk);
        #1;
        check("pre_reset_err", 32'(err1), 32'd2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_ab", 32'({a1, b1}), 32'd0);
        check("midrst_flags", 32'({busy1, done1, pass1}), 32'd0);
        check("midrst_err_fail", 32'({err1, fail1}), 32'd0);
        check("midrst_state", 32'(st1), 32'd0);
        rst_n = 1'b1;
        mode1 = 0;
        cnt = 0;
        for (int n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (done1) cnt++;
        end
        check("midrst_no_done", 32'(cnt), 32'd0);
        run1(1'b0, dc, cnt);
        check("after_rst_done_cycle", 32'(dc), 32'd45);
        check("after_rst_pass", 32'(pass1), 32'd1);

        // Stuck-at-1 output
        mode1 = 1;
        run1(1'b0, dc, cnt);
        check("stuck1_err", 32'(err1), 32'd3);
        check("stuck1_fail", 32'(fail1), 32'b1110);
        check("stuck1_pass", 32'(pass1), 32'd0);

        // OR gate against NOR table
        mode1 = 2;
        run1(1'b0, dc, cnt);
        check("or_err", 32'(err1), 32'd4);
        check("or_fail", 32'(fail1), 32'b1111);
        check("or_pass", 32'(pass1), 32'd0);
        check("or_hold_after", 32'({err1, fail1}), 32'({3'd4, 4'b1111}));

        // NAND table, settle 3
        mode2 = 0;
        run2(dc);
        check("nand_done_cycle", 32'(dc), 32'd17);
        check("nand_pass", 32'(pass2), 32'd1);
        check("nand_err_fail", 32'({err2, fail2}), 32'd0);
        mode2 = 1;
        run2(dc);
        check("nand_vs_nor_done", 32'(dc), 32'd17);
        check("nand_vs_nor_fail", 32'(fail2), 32'b0110);
        check("nand_vs_nor_err", 32'(err2), 32'd2);
        check("nand_vs_nor_pass", 32'(pass2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
